// File: rtl/shift_pkg.sv
// Shared types for the sequential shift/rotate unit and its single-step helper.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_LSL = 3'd0,
        OP_LSR = 3'd1,
        OP_ASR = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        case (shift_op_e'(op))
            OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One 1-bit shift/rotate step on a WIDTH-bit word; purely combinational.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = data;
        case (shift_op_e'(op))
            OP_LSL:  result = {data[WIDTH-2:0], 1'b0};
            OP_LSR:  result = {1'b0, data[WIDTH-1:1]};
            OP_ASR:  result = {data[WIDTH-1], data[WIDTH-1:1]};
            OP_ROL:  result = {data[WIDTH-2:0], data[WIDTH-1]};
            OP_ROR:  result = {data[0], data[WIDTH-1:1]};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Sequential variable-amount shifter: one 1-bit step per clock, valid/ready on both sides.
module shift_seq_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             busy
);

    shift_state_e     state;
    logic [WIDTH-1:0] data;
    logic [2:0]       op;
    logic [AMT_W-1:0] cnt;
    logic             err;
    logic             valid;
    logic             busy_r;
    logic [WIDTH-1:0] step_data;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data   (data),
        .op     (op),
        .result (step_data)
    );

    // out_valid/busy are registered alongside the state so they change exactly with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            data   <= '0;
            op     <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            valid  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data   <= in_data;
                        op     <= in_op;
                        cnt    <= in_amt;
                        err    <= !is_legal_op(in_op);
                        busy_r <= 1'b1;
                        if (in_amt == '0 || !is_legal_op(in_op)) begin
                            state <= ST_DONE;
                            valid <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    data <= step_data;
                    cnt  <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state <= ST_DONE;
                        valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state  <= ST_IDLE;
                        valid  <= 1'b0;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    valid  <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = valid;
    assign out_data  = data;
    assign out_err   = err;
    assign busy      = busy_r;

endmodule
